// File: rtl/cmos_wr_pkg.sv
// Shared types and widths for the CMOS capture -> SDRAM write-port gate.
package cmos_wr_pkg;

  localparam int PIX_W  = 16;
  localparam int PORT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    ACTIVE,
    DROP
  } wr_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/edge_det.sv
// Registered single-bit edge detector; RISING selects rise (1) or fall (0) detection.
module edge_det #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_reg;

  always_ff @(posedge clk) begin
    if (rst) d_reg <= 1'b0;
    else     d_reg <= d;
  end

  generate
    if (RISING) begin : g_rise
      assign pulse = d & ~d_reg;
    end else begin : g_fall
      assign pulse = ~d & d_reg;
    end
  endgenerate

endmodule

// File: rtl/cmos_frame_writer.sv
// Frame-synchronous gate from the RGB565 capture stage to SDRAM write port 1.
// Optional good/bad frame counters are built when FRAME_STATS_EN is defined.
module cmos_frame_writer
  import cmos_wr_pkg::*;
#(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int DW    = PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_vsync,
  input  logic              in_href,
  input  logic              in_clken,
  input  logic [DW-1:0]     in_data,
  input  logic              wr_full,
  output logic              wr_en,
  output logic [PORT_W-1:0] wr_data,
  output logic              wr_load,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        err_cnt
);

  localparam int XW = $clog2(H_ACT + 1);
  localparam int YW = $clog2(V_ACT + 2);
  localparam logic [XW-1:0] X_FULL = XW'(H_ACT);
  localparam logic [YW-1:0] Y_FULL = YW'(V_ACT);
  localparam logic [YW-1:0] Y_SAT  = YW'(V_ACT + 1);

  logic vs_rise;
  logic href_fall;
  logic pixel;

  edge_det #(.RISING(1'b1)) u_vs_det (
    .clk   (clk),
    .rst   (rst),
    .d     (in_vsync),
    .pulse (vs_rise)
  );

  edge_det #(.RISING(1'b0)) u_href_det (
    .clk   (clk),
    .rst   (rst),
    .d     (in_href),
    .pulse (href_fall)
  );

  assign pixel = in_href & in_clken;

  wr_state_t         state_reg, state_next;
  logic [XW-1:0]     x_reg, x_next;
  logic [YW-1:0]     y_reg, y_next;
  logic              err_reg, err_next;
  logic              wr_en_reg, wr_en_next;
  logic [PORT_W-1:0] wr_data_reg, wr_data_next;
  logic              wr_load_reg, wr_load_next;
  logic              done_reg, done_next;
  logic              ferr_reg, ferr_next;
  logic              close_frame;
  logic              open_frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      x_reg       <= '0;
      y_reg       <= '0;
      err_reg     <= 1'b0;
      wr_en_reg   <= 1'b0;
      wr_data_reg <= '0;
      wr_load_reg <= 1'b0;
      done_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      err_reg     <= err_next;
      wr_en_reg   <= wr_en_next;
      wr_data_reg <= wr_data_next;
      wr_load_reg <= wr_load_next;
      done_reg    <= done_next;
      ferr_reg    <= ferr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    err_next     = err_reg;
    wr_en_next   = 1'b0;
    wr_data_next = wr_data_reg;
    wr_load_next = 1'b0;
    done_next    = 1'b0;
    ferr_next    = 1'b0;
    close_frame  = 1'b0;
    open_frame   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (enable) state_next = WAIT_VS;
      end
      WAIT_VS: begin
        if (vs_rise) begin
          if (enable) open_frame = 1'b1;
          else        state_next = IDLE;
        end
      end
      ACTIVE: begin
        // A frame start outranks any pixel or line end arriving in the same cycle.
        if (vs_rise) begin
          close_frame = 1'b1;
        end else begin
          if (pixel) begin
            if (wr_full) begin
              err_next   = 1'b1;
              state_next = DROP;
            end else if (x_reg < X_FULL) begin
              wr_en_next   = 1'b1;
              wr_data_next = PORT_W'(in_data);
              x_next       = x_reg + 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end
          if (href_fall) begin
            if (x_reg != X_FULL) err_next = 1'b1;
            x_next = '0;
            if (y_reg != Y_SAT) y_next = y_reg + 1'b1;
          end
        end
      end
      DROP: begin
        if (vs_rise) close_frame = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    if (close_frame) begin
      done_next = ~err_reg & (y_reg == Y_FULL);
      ferr_next = ~(~err_reg & (y_reg == Y_FULL));
      if (enable) open_frame = 1'b1;
      else        state_next = IDLE;
    end

    if (open_frame) begin
      state_next   = ACTIVE;
      wr_load_next = 1'b1;
      x_next       = '0;
      y_next       = '0;
      err_next     = 1'b0;
    end
  end

  assign wr_en      = wr_en_reg;
  assign wr_data    = wr_data_reg;
  assign wr_load    = wr_load_reg;
  assign frame_done = done_reg;
  assign frame_err  = ferr_reg;

`ifdef FRAME_STATS_EN
  logic [15:0] frame_cnt_reg;
  logic [7:0]  err_cnt_reg;

  // Counters step on the same edge that raises the matching pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg <= '0;
      err_cnt_reg   <= '0;
    end else begin
      if (done_next && frame_cnt_reg != 16'hFFFF) frame_cnt_reg <= frame_cnt_reg + 16'd1;
      if (ferr_next && err_cnt_reg != 8'hFF)      err_cnt_reg   <= err_cnt_reg + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
  assign err_cnt   = err_cnt_reg;
`else
  assign frame_cnt = 16'd0;
  assign err_cnt   = 8'd0;
`endif

endmodule
